// File: rtl/seg7_scan_if.sv
// Bus between number-formatting logic (master) and the seven-segment
// scan controller (slave): digit data and controls in, display pins out.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    load;
    logic                    lz_en;
    logic [3:0]              bright;
    logic [6:0]              seg_S;
    logic [NUM_DIGITS-1:0]   com_s;
    logic                    dp;
    logic                    frame;

    modport master (
        output digits_i, dp_i, blank_i, load, lz_en, bright,
        input  seg_S, com_s, dp, frame
    );

    modport slave (
        input  digits_i, dp_i, blank_i, load, lz_en, bright,
        output seg_S, com_s, dp, frame
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with per-digit decimal
// points, blanking, leading-zero suppression, frame-synchronous double
// buffering, PWM brightness and configurable pin polarity.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int PRESCALE_BITS   = 14,
    parameter bit COM_ACTIVE_HIGH = 1'b1,
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input logic        fin,
    input logic        rst,
    seg7_scan_if.slave bus
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  COM_INV  = !COM_ACTIVE_HIGH;
    localparam logic                  SEG_INV  = !SEG_ACTIVE_HIGH;
    localparam logic [NUM_DIGITS-1:0] COM_OFF  = {NUM_DIGITS{COM_INV}};
    localparam logic [6:0]            SEG_OFF  = {7{SEG_INV}};

    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     frame_q;

    logic [4*NUM_DIGITS-1:0]  shadow_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]    shadow_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]    shadow_blank_q, act_blank_q;

    logic [6:0]               seg_q;
    logic [NUM_DIGITS-1:0]    com_q;
    logic                     dp_q;

    logic                     tick;
    logic                     wrap_tick;

    assign tick      = &prescale_q;
    assign wrap_tick = tick && (idx_q == LAST_IDX);

    // Free-running slot prescaler, digit index and the end-of-frame pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            idx_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
            frame_q    <= wrap_tick;
            if (tick) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Shadow registers: any load cycle overwrites, last write wins.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_blank_q  <= '0;
        end else if (bus.load) begin
            shadow_digits_q <= bus.digits_i;
            shadow_dp_q     <= bus.dp_i;
            shadow_blank_q  <= bus.blank_i;
        end
    end

    // Active registers only change on the wrap, so a frame never tears.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
        end else if (wrap_tick) begin
            act_digits_q <= shadow_digits_q;
            act_dp_q     <= shadow_dp_q;
            act_blank_q  <= shadow_blank_q;
        end
    end

    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  zero_run;

    // Leading-zero run from the left; blanked digits extend the run and the
    // rightmost digit is never suppressed.
    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            zero_run   = zero_run && (act_blank_q[k] ||
                         (act_digits_q[4*k +: 4] == 4'd0 && !act_dp_q[k]));
            lz_dark[k] = bus.lz_en && zero_run;
        end
    end

    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [6:0]            seg_dec;
    logic [3:0]            phase;
    logic                  com_on;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] com_n;

    // Select the scanned digit, decode it and compute the PWM-gated select.
    always_comb begin
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        com_n    = '0;
        phase    = prescale_q[PRESCALE_BITS-1 -: 4];
        com_on   = (bus.bright == 4'hF) || (phase < bus.bright);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_code                 = act_digits_q[4*k +: 4];
                cur_dp                   = act_dp_q[k];
                cur_dark                 = act_blank_q[k] || lz_dark[k];
                com_n[NUM_DIGITS-1-k]    = com_on;
            end
        end
        case (cur_code)
            4'd0:    seg_dec = 7'h7E;
            4'd1:    seg_dec = 7'h30;
            4'd2:    seg_dec = 7'h6D;
            4'd3:    seg_dec = 7'h79;
            4'd4:    seg_dec = 7'h33;
            4'd5:    seg_dec = 7'h5B;
            4'd6:    seg_dec = 7'h5F;
            4'd7:    seg_dec = 7'h70;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h7B;
            default: seg_dec = 7'h00;
        endcase
        seg_n = cur_dark ? 7'h00 : seg_dec;
        dp_n  = !cur_dark && cur_dp;
    end

    // Registered pins with polarity applied; reset drives the dark level.
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            com_q <= COM_OFF;
            dp_q  <= SEG_INV;
        end else begin
            seg_q <= seg_n ^ SEG_OFF;
            com_q <= com_n ^ COM_OFF;
            dp_q  <= dp_n ^ SEG_INV;
        end
    end

    assign bus.seg_S = seg_q;
    assign bus.com_s = com_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 32-cycle slots, active-high.
module tb_seg7_scan_ctrl;

    logic fin = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seg7_scan_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .PRESCALE_BITS  (5),
        .COM_ACTIVE_HIGH(1'b1),
        .SEG_ACTIVE_HIGH(1'b1)
    ) dut (
        .fin(fin),
        .rst(rst),
        .bus(bus)
    );

    always #5 fin = ~fin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse load for one cycle with the given buffer contents.
    task automatic load_vec(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bus.digits_i = d;
        bus.dp_i     = p;
        bus.blank_i  = b;
        bus.load     = 1'b1;
        @(negedge fin);
        bus.load     = 1'b0;
    endtask

    // Returns at the negedge where frame is high (outputs still show the last slot).
    task automatic wait_frame(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge fin);
            if (bus.frame) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check(tag, 32'd0, 32'd1);
    endtask

    // Called at the frame negedge; checks each slot at its midpoint.
    // exp_seg = {seg0,seg1,seg2,seg3}, exp_dp bit k = digit k.
    task automatic sample_slots(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
        logic [3:0] exp_com;
        repeat (17) @(negedge fin);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (32) @(negedge fin);
            exp_com = 4'b1000 >> k;
            check($sformatf("%s_seg%0d", tag, k), bus.seg_S, exp_seg[27-7*k -: 7]);
            check($sformatf("%s_com%0d", tag, k), bus.com_s, exp_com);
            check($sformatf("%s_dp%0d", tag, k), bus.dp, exp_dp[k]);
        end
    endtask

    initial begin
        int cnt;
        bus.digits_i = '0;
        bus.dp_i     = '0;
        bus.blank_i  = '0;
        bus.load     = 1'b0;
        bus.lz_en    = 1'b0;
        bus.bright   = 4'd15;

        // Reset state.
        repeat (3) @(negedge fin);
        check("rst_com", bus.com_s, 4'b0000);
        check("rst_seg", bus.seg_S, 7'h00);
        check("rst_dp", bus.dp, 1'b0);
        check("rst_frame", bus.frame, 1'b0);
        rst = 1'b0;

        // 1: basic scan of 1,4,5,7 with dp on digit 0.
        load_vec(16'h7541, 4'b0001, 4'b0000);
        wait_frame("t1_frame_to");
        sample_slots("t1", {7'h30, 7'h33, 7'h5B, 7'h70}, 4'b0001);
        wait_frame("t1b_frame_to");
        @(negedge fin);
        check("t1_frame_width", bus.frame, 1'b0);
        check("t1_slot0_first", bus.com_s, 4'b1000);
        repeat (31) @(negedge fin);
        check("t1_slot0_last", bus.com_s, 4'b1000);
        @(negedge fin);
        check("t1_slot1_first", bus.com_s, 4'b0100);

        // 2: leading-zero suppression, then a dp breaking the zero run.
        bus.lz_en = 1'b1;
        load_vec(16'h0300, 4'b0000, 4'b0000);
        wait_frame("t2_frame_to");
        sample_slots("t2a", {7'h00, 7'h00, 7'h79, 7'h7E}, 4'b0000);
        load_vec(16'h0300, 4'b0010, 4'b0000);
        wait_frame("t2b_frame_to");
        sample_slots("t2b", {7'h00, 7'h7E, 7'h79, 7'h7E}, 4'b0010);

        // 3: mid-frame load must not tear the current frame.
        wait_frame("t3_frame_to");
        repeat (1 + 32 + 16) @(negedge fin);
        load_vec(16'h9999, 4'b0000, 4'b0000);
        repeat (31) @(negedge fin);
        check("t3_old_seg2", bus.seg_S, 7'h79);
        repeat (32) @(negedge fin);
        check("t3_old_seg3", bus.seg_S, 7'h7E);
        wait_frame("t3b_frame_to");
        sample_slots("t3", {7'h7B, 7'h7B, 7'h7B, 7'h7B}, 4'b0000);

        // 4: PWM brightness.
        bus.bright = 4'd4;
        wait_frame("t4_frame_to");
        @(negedge fin);
        check("t4_com_on", bus.com_s, 4'b1000);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.com_s != 4'b0000) cnt++;
            @(negedge fin);
        end
        check("t4_duty_b4", cnt, 8);
        bus.bright = 4'd0;
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge fin);
            if (bus.com_s != 4'b0000) cnt++;
        end
        check("t4_duty_b0", cnt, 0);
        check("t4_seg_driven", bus.seg_S, 7'h7B);
        bus.bright = 4'd15;

        // 5: invalid codes, blanking, all-zero suppression, blank inside a zero run.
        bus.lz_en = 1'b0;
        load_vec(16'hC65C, 4'b0110, 4'b0100);
        wait_frame("t5a_frame_to");
        sample_slots("t5a", {7'h00, 7'h5B, 7'h00, 7'h00}, 4'b0010);
        bus.lz_en = 1'b1;
        load_vec(16'h0000, 4'b0000, 4'b0000);
        wait_frame("t5b_frame_to");
        sample_slots("t5b", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000);
        load_vec(16'h2050, 4'b0000, 4'b0010);
        wait_frame("t5c_frame_to");
        sample_slots("t5c", {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0000);

        // 6: asynchronous reset mid-slot, then restart at digit 0 showing zeros.
        bus.lz_en = 1'b0;
        load_vec(16'h8888, 4'b1111, 4'b0000);
        wait_frame("t6_frame_to");
        repeat (11) @(negedge fin);
        check("t6_pre_seg", bus.seg_S, 7'h7F);
        rst = 1'b1;
        #1;
        check("t6_rst_com", bus.com_s, 4'b0000);
        check("t6_rst_seg", bus.seg_S, 7'h00);
        check("t6_rst_dp", bus.dp, 1'b0);
        @(negedge fin);
        rst = 1'b0;
        @(negedge fin);
        check("t6_restart_com", bus.com_s, 4'b1000);
        check("t6_restart_seg", bus.seg_S, 7'h7E);
        check("t6_restart_dp", bus.dp, 1'b0);
        repeat (32) @(negedge fin);
        check("t6_slot1_com", bus.com_s, 4'b0100);
        check("t6_slot1_seg", bus.seg_S, 7'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
